// File: rtl/pixie_video_gen_if.sv
// pixie_video_gen_if: CPU strobe/DMA inputs and video/timing outputs of the Pixie generator.
//   slave  : the generator (inputs disp_on, disp_off, tpb, sc, data_in, row_rpt;
//            outputs int_n, dmao_n, efx_n, video, hsync_n, vsync_n, comp_sync, line_active)
//   master : the CPU/bench side driving the strobes and observing the outputs
interface pixie_video_gen_if;
  logic       disp_on, disp_off, tpb;
  logic [1:0] sc;
  logic [7:0] data_in;
  logic [1:0] row_rpt;
  logic       int_n, dmao_n, efx_n, video, hsync_n, vsync_n, comp_sync, line_active;
  modport master (
    output disp_on, disp_off, tpb, sc, data_in, row_rpt,
    input  int_n, dmao_n, efx_n, video, hsync_n, vsync_n, comp_sync, line_active
  );
  modport slave (
    input  disp_on, disp_off, tpb, sc, data_in, row_rpt,
    output int_n, dmao_n, efx_n, video, hsync_n, vsync_n, comp_sync, line_active
  );
endinterface

// File: rtl/pixie_video_gen.sv
// pixie_video_gen: CDP1861-style display timing, DMA request and 1-bit video serialiser.
//   clock, reset (sync, active-low), bus (pixie_video_gen_if.slave).
//   Define PIXIE_LINEBUF_EN to add the line buffer with row-repeat replay (row_rpt);
//   without it every active line is fetched by DMA and row_rpt is ignored.
module pixie_video_gen #(
  parameter int MC_PER_LINE = 29,
  parameter int LINES       = 262,
  parameter int VSYNC_LINES = 16,
  parameter int HSYNC_MC    = 3,
  parameter int ACT_START   = 80,
  parameter int ACT_LINES   = 128,
  parameter int DMA_START   = 3,
  parameter int DMA_BYTES   = 8,
  parameter int EF_LEAD     = 4,
  parameter int EF_TAIL     = 4
) (
  input logic clock,
  input logic reset,
  pixie_video_gen_if.slave bus
);
  localparam int MCW = $clog2(MC_PER_LINE);
  localparam int LW  = $clog2(LINES);
  logic [MCW-1:0] mc_q, mc_d;
  logic [LW-1:0]  line_q, line_d;
  logic           en_q, en_d, gate_q, gate_d;
  logic [7:0]     shift_q, shift_d;
  logic           int_n_q, int_n_d, dmao_n_q, dmao_n_d, efx_n_q, efx_n_d, video_q, video_d;
  logic           hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d, comp_sync_q, comp_sync_d;
  logic           line_active_q, line_active_d;
  logic           mc_wrap, active, win, fetch, dma, wr;
  int             ln, mcn;
`ifdef PIXIE_LINEBUF_EN
  localparam int BW = DMA_BYTES > 1 ? $clog2(DMA_BYTES) : 1;
  logic [1:0]     rpt_q, rpt_d;
  logic [BW-1:0]  slot;
  logic [7:0]     line_buf_q [DMA_BYTES];
`else
  logic           unused_row_rpt;
  assign unused_row_rpt = ^bus.row_rpt;
`endif
  always_comb begin
    ln = int'(line_q);
    mcn = int'(mc_q);
    mc_wrap = bus.tpb && mcn == MC_PER_LINE - 1;
    mc_d = !bus.tpb ? mc_q : mc_wrap ? '0 : MCW'(mcn + 1);
    line_d = !mc_wrap ? line_q : ln == LINES - 1 ? '0 : LW'(ln + 1);
    en_d = bus.disp_off ? 1'b0 : bus.disp_on ? 1'b1 : en_q;
    // the gate freezes the enable for a whole line so DMA never starts mid-line
    gate_d = mc_wrap ? en_d : gate_q;
    active = ln >= ACT_START && ln < ACT_START + ACT_LINES;
    win = mcn >= DMA_START && mcn < DMA_START + DMA_BYTES;
    dma = gate_q && active && win;
    wr = dma && fetch && bus.tpb && bus.sc == 2'd2;
`ifdef PIXIE_LINEBUF_EN
    rpt_d = mc_wrap && ln == LINES - 1 ? bus.row_rpt : rpt_q;
    // repeat factor is a power of two, so the modulo reduces to a mask
    fetch = ((ln - ACT_START) & ((1 << rpt_q) - 1)) == 0;
    slot = BW'(mcn - DMA_START);
    shift_d = wr ? bus.data_in :
              dma && !fetch && bus.tpb ? line_buf_q[slot] : {shift_q[6:0], 1'b0};
`else
    fetch = 1'b1;
    shift_d = wr ? bus.data_in : {shift_q[6:0], 1'b0};
`endif
    hsync_n_d = mcn >= HSYNC_MC;
    vsync_n_d = ln >= VSYNC_LINES;
    comp_sync_d = ~(hsync_n_d ^ vsync_n_d);
    dmao_n_d = !(dma && fetch);
    int_n_d = !(gate_q && (ln == ACT_START - 2 || ln == ACT_START - 1));
    efx_n_d = !((ln >= ACT_START - EF_LEAD && ln < ACT_START) ||
                (ln >= ACT_START + ACT_LINES - EF_TAIL && ln < ACT_START + ACT_LINES));
    video_d = shift_q[7];
    line_active_d = gate_q && active;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      mc_q <= '0;
      line_q <= '0;
      en_q <= 1'b0;
      gate_q <= 1'b0;
      shift_q <= '0;
      int_n_q <= 1'b1;
      dmao_n_q <= 1'b1;
      efx_n_q <= 1'b1;
      video_q <= 1'b0;
      hsync_n_q <= 1'b0;
      vsync_n_q <= 1'b0;
      comp_sync_q <= 1'b1;
      line_active_q <= 1'b0;
`ifdef PIXIE_LINEBUF_EN
      rpt_q <= '0;
`endif
    end else begin
      mc_q <= mc_d;
      line_q <= line_d;
      en_q <= en_d;
      gate_q <= gate_d;
      shift_q <= shift_d;
      int_n_q <= int_n_d;
      dmao_n_q <= dmao_n_d;
      efx_n_q <= efx_n_d;
      video_q <= video_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      comp_sync_q <= comp_sync_d;
      line_active_q <= line_active_d;
`ifdef PIXIE_LINEBUF_EN
      rpt_q <= rpt_d;
`endif
    end
  end
`ifdef PIXIE_LINEBUF_EN
  always_ff @(posedge clock)
    if (reset && wr) line_buf_q[slot] <= bus.data_in;
`endif
  assign bus.int_n = int_n_q;
  assign bus.dmao_n = dmao_n_q;
  assign bus.efx_n = efx_n_q;
  assign bus.video = video_q;
  assign bus.hsync_n = hsync_n_q;
  assign bus.vsync_n = vsync_n_q;
  assign bus.comp_sync = comp_sync_q;
  assign bus.line_active = line_active_q;
endmodule

// File: tb/tb_pixie_video_gen.sv
// tb_pixie_video_gen: randomized directed run of pixie_video_gen against a frame-level reference model.
module tb_pixie_video_gen;
  localparam int MC_PER_LINE = 29, LINES = 262, VSYNC_LINES = 16, HSYNC_MC = 3;
  localparam int ACT_START = 80, ACT_LINES = 128, DMA_START = 3, DMA_BYTES = 8;
  localparam int EF_LEAD = 4, EF_TAIL = 4;
`ifdef PIXIE_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  pixie_video_gen_if bus();
  pixie_video_gen dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int tline = 0, tmc = 0, tfac = 0, cyc = 0, load_cyc = -100, dcount = 0, cap_n = 0;
  bit ten = 0, tgate = 0, cap_arm = 0;
  logic [7:0] load_byte = 0, cap = 0;
  logic [7:0] tbuf [DMA_BYTES];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (line %0d mc %0d)", tag, obs, exp, tline, tmc);
    end
  endtask

  // one clock: drive inputs, predict outputs from the model, compare after the edge, advance the model
  task automatic step(input logic t, input logic [1:0] s, input logic [7:0] d,
                      input logic on, input logic off, input logic rn);
    bit act, win, fetch, dma, en_n;
    int n;
    logic e_hs, e_vs, e_video;
    bus.tpb = t; bus.sc = s; bus.data_in = d; bus.disp_on = on; bus.disp_off = off; reset = rn;
    act = tline >= ACT_START && tline < ACT_START + ACT_LINES;
    win = tmc >= DMA_START && tmc < DMA_START + DMA_BYTES;
    fetch = act && ((tline - ACT_START) % (1 << tfac)) == 0;
    dma = tgate && act && win;
    n = cyc - 1 - load_cyc;
    e_video = (n >= 0 && n < 8) ? load_byte[7-n] : 1'b0;
    e_hs = tmc >= HSYNC_MC;
    e_vs = tline >= VSYNC_LINES;
    @(posedge clock);
    #1;
    if (!rn) begin
      chk("rst_int_n", 8'(bus.int_n), 8'd1);
      chk("rst_dmao_n", 8'(bus.dmao_n), 8'd1);
      chk("rst_efx_n", 8'(bus.efx_n), 8'd1);
      chk("rst_video", 8'(bus.video), 8'd0);
      chk("rst_hsync_n", 8'(bus.hsync_n), 8'd0);
      chk("rst_vsync_n", 8'(bus.vsync_n), 8'd0);
      chk("rst_comp_sync", 8'(bus.comp_sync), 8'd1);
      chk("rst_line_active", 8'(bus.line_active), 8'd0);
      tline = 0; tmc = 0; ten = 0; tgate = 0; tfac = 0; load_cyc = -100; cap_n = 0;
    end else begin
      chk("hsync_n", 8'(bus.hsync_n), 8'(e_hs));
      chk("vsync_n", 8'(bus.vsync_n), 8'(e_vs));
      chk("comp_sync", 8'(bus.comp_sync), 8'(!(e_hs ^ e_vs)));
      chk("dmao_n", 8'(bus.dmao_n), 8'(!(dma && fetch)));
      chk("int_n", 8'(bus.int_n), 8'(!(tgate && (tline == ACT_START-2 || tline == ACT_START-1))));
      chk("efx_n", 8'(bus.efx_n), 8'(!((tline >= ACT_START-EF_LEAD && tline < ACT_START) ||
          (tline >= ACT_START+ACT_LINES-EF_TAIL && tline < ACT_START+ACT_LINES))));
      chk("line_active", 8'(bus.line_active), 8'(tgate && act));
      chk("video", 8'(bus.video), 8'(e_video));
      if (t && bus.dmao_n === 1'b0) dcount++;
      if (cap_n > 0) begin cap = {cap[6:0], bus.video}; cap_n--; end
      if (t && dma) begin
        if (fetch) begin
          if (s == 2'd2) begin tbuf[tmc-DMA_START] = d; load_cyc = cyc; load_byte = d; end
        end else begin
          load_cyc = cyc; load_byte = tbuf[tmc-DMA_START];
        end
        if (cap_arm && fetch && s == 2'd2 && tline == ACT_START && tmc == DMA_START) begin
          cap_n = 8; cap_arm = 0;
        end
      end
      en_n = off ? 1'b0 : on ? 1'b1 : ten;
      ten = en_n;
      if (t) begin
        if (tmc == MC_PER_LINE - 1) begin
          tmc = 0;
          tline = (tline + 1) % LINES;
          tgate = en_n;
          if (tline == 0 && LB) tfac = int'(bus.row_rpt);
        end else tmc++;
      end
    end
    cyc++;
  endtask

  // one machine cycle; slow (8 clocks) around the first active lines' DMA window so pixels are visible
  task automatic run_mc();
    int gap;
    gap = (tline >= ACT_START && tline < ACT_START + 4 && tmc >= DMA_START && tmc <= DMA_START + DMA_BYTES) ? 8 : 1;
    for (int i = 1; i < gap; i++) step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0, 1'b0, 1'b1);
    step(1'b1, (tmc >= DMA_START && tmc < DMA_START + DMA_BYTES) ? 2'd2 : 2'($urandom_range(0, 3)),
         (tline == ACT_START && tmc == DMA_START) ? 8'hA5 : 8'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_to(input int l, input int m);
    int k;
    k = 0;
    do begin run_mc(); k++; end while (!(tline == l && tmc == m) && k < 20000);
    if (k >= 20000) begin
      checks++; failures++;
      $error("FAIL run_to_bound observed line=%0d mc=%0d expected line=%0d mc=%0d", tline, tmc, l, m);
    end
  endtask

  initial begin
    bus.disp_on = 0; bus.disp_off = 0; bus.tpb = 0; bus.sc = 0; bus.data_in = 0; bus.row_rpt = 0;
    step(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 8'hFF, 1'b1, 1'b0, 1'b0);
    // two frames with the display off
    dcount = 0;
    run_to(0, 0);
    run_to(0, 0);
    chk("off_dma_count", 8'(dcount), 8'd0);
    // enable mid-line at line 100, mc 5: first request at line 101, mc 3
    run_to(100, 5);
    step(1'b0, 2'd2, 8'h3C, 1'b1, 1'b0, 1'b1);
    run_to(0, 0);
    // full frame at factor 1; row_rpt changed mid-frame only takes effect next frame
    dcount = 0; cap_arm = 1;
    run_to(150, 0);
    bus.row_rpt = 2'd2;
    run_to(0, 0);
    chk("rpt1_dma_count", 16'(dcount) == 16'd1024 ? 8'd1 : 8'd0, 8'd1);
    chk("video_a5", cap, 8'hA5);
    dcount = 0;
    run_to(150, 0);
    bus.row_rpt = 2'd3;
    run_to(0, 0);
    chk("rpt4_dma_count", 16'(dcount) == (LB ? 16'd256 : 16'd1024) ? 8'd1 : 8'd0, 8'd1);
    dcount = 0;
    run_to(0, 0);
    chk("rpt8_dma_count", 16'(dcount) == (LB ? 16'd128 : 16'd1024) ? 8'd1 : 8'd0, 8'd1);
    // disable, then simultaneous on/off must leave the display off
    dcount = 0;
    step(1'b0, 2'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    run_to(101, 12);
    chk("onoff_dma_count", 8'(dcount), 8'd0);
    // reset mid-frame, then restart from line 0 with the display off
    run_to(150, 0);
    step(1'b1, 2'd2, 8'h81, 1'b1, 1'b0, 1'b0);
    dcount = 0;
    run_to(20, 0);
    chk("post_reset_dma_count", 8'(dcount), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixie_video_gen.md
Name: pixie_video_gen

Overview:
- Parametrised successor to the CDP1861 display controller in the RCA Studio II core.
- Generates sync, interrupt, flag and DMA-request timing from CDP1802 machine-cycle strobes.
- Serialises DMA display bytes into 1-bit video.
- Adds a programmable row-repeat mode: a line captured by DMA is replayed from an internal line buffer, so repeated rows cost no CPU DMA cycles.

Parameters:
- MC_PER_LINE, 29: machine cycles per scan line.
- LINES, 262: scan lines per frame.
- VSYNC_LINES, 16: lines 0..VSYNC_LINES-1 have vsync asserted.
- HSYNC_MC, 3: machine cycles 0..HSYNC_MC-1 of each line have hsync asserted.
- ACT_START, 80: first active display line.
- ACT_LINES, 128: number of active display lines.
- DMA_START, 3: first DMA machine cycle in an active line.
- DMA_BYTES, 8: DMA bytes per line; also the line-buffer depth.
- EF_LEAD, 4: number of lines before ACT_START with efx_n low.
- EF_TAIL, 4: number of final active lines with efx_n low.

Ports:
- clock, in, 1: system clock; every register updates on its rising edge.
- reset, in, 1: synchronous, active-low.
- disp_on, in, 1: one-clock pulse that enables the display.
- disp_off, in, 1: one-clock pulse that disables the display.
- tpb, in, 1: CPU TPB strobe, one clock wide, once per machine cycle.
- sc, in, 2: CPU state code; 2 means DMA cycle.
- data_in, in, 8: CPU data bus, sampled on DMA cycles.
- row_rpt, in, 2: row repeat factor 1/2/4/8 for codes 0/1/2/3; sampled at frame start.
- int_n, out, 1: interrupt request, active-low.
- dmao_n, out, 1: DMA-out request, active-low.
- efx_n, out, 1: display flag, active-low.
- video, out, 1: serial pixel output.
- hsync_n, out, 1: horizontal sync, active-low.
- vsync_n, out, 1: vertical sync, active-low.
- comp_sync, out, 1: equals ~(hsync_n ^ vsync_n).
- line_active, out, 1: high during active lines while the display is enabled.

Behaviour:
- Reset values: int_n=1, dmao_n=1, efx_n=1, video=0, hsync_n=0, vsync_n=0, comp_sync=1, line_active=0.
  - Reset also clears mc, line, repeat counter, display enable and shifter.
  - Line-buffer contents are undefined after reset.
- Counters:
  - mc counts 0..MC_PER_LINE-1 and increments on each tpb.
  - At wrap, mc returns to 0 and line increments; line wraps LINES-1 -> 0.
  - Counter widths are clog2 of their range.
- Display enable: set by disp_on, cleared by disp_off. If both pulse together, disp_off wins.
  - The enable is sampled into a line-gate at every line start (mc wrap). All DMA and interrupt decisions use the gate, so a mid-line disp_on never produces a partial DMA line.
- row_rpt is latched when line wraps to 0; a mid-frame change has no effect until the next frame.
- Active line: ACT_START <= line < ACT_START+ACT_LINES.
- Repeat position: rp = (line-ACT_START) mod factor.
  - Fetch line: rp==0. Replay line: rp!=0.
- DMA (fetch lines only, gate set):
  - dmao_n low while DMA_START <= mc < DMA_START+DMA_BYTES.
  - On each tpb with sc==2, data_in is loaded into the shifter and written to buffer[mc-DMA_START].
  - sc==2 outside the window is ignored.
- Replay lines: dmao_n stays high. On tpb at the same mc slots, buffer[mc-DMA_START] loads the shifter.
- Shifter: after a load, shifts left one bit per clock with 0 fill. video is a registered copy of bit 7 (one-clock latency). Line count and pixel placement are therefore unchanged by the repeat factor.
- int_n: low on lines ACT_START-2 and ACT_START-1 when the gate is set; high otherwise.
- efx_n: low on lines ACT_START-EF_LEAD..ACT_START-1 and on the last EF_TAIL active lines, regardless of display enable.
- Registration: all outputs are registered and update one clock after the counter state that causes them.
- Reset mid-frame: outputs return to reset values on the next edge. Counting restarts at line 0, mc 0, with the display disabled.

Optional Feature:
- Macro: PIXIE_LINEBUF_EN.
- Defined: line buffer and row-repeat replay are implemented as described above.
- Undefined: no buffer, row_rpt is ignored, and every active line is a fetch line. The output timing is identical to factor 1.

Test Plan:
- Defaults, display off, 2 frames -> hsync_n low mc 0..2 each line; vsync_n low lines 0..15; dmao_n and int_n stay 1; efx_n low lines 76..79 and 204..207.
- disp_on, row_rpt=0 -> int_n low lines 78..79; dmao_n low mc 3..10 on all 128 active lines (1024 requests/frame); byte 0xA5 at slot 0 gives video bits 1,0,1,0,0,1,0,1.
- row_rpt=2 (factor 4), distinct bytes per fetch line -> DMA only on lines 80,84,...,204 (256 requests/frame); lines 81..83 replay line 80's bytes bit-exactly.
- disp_on pulsed at line 100, mc 5 -> no dmao_n until line 101, mc 3; disp_on and disp_off in the same clock -> display stays off.
- reset low at line 150 -> next edge: all outputs at reset values; restart from line 0 with the display off.
- PIXIE_LINEBUF_EN undefined, row_rpt=3 -> 1024 DMA requests/frame, identical to row_rpt=0.
